// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// the default requester count.
package mem_arbiter_pkg;

    localparam int NUM_MEM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } mem_arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner selection: first set request at or after i_ptr,
// wrapping. A constant-zero pointer gives plain lowest-index priority.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic               o_valid,
    output logic [IW-1:0]      o_idx
);

    logic [IW:0] pos;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        pos     = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            pos = {1'b0, i_ptr} + (IW+1)'(off);
            if (pos >= (IW+1)'(NUM_REQ)) begin
                pos = pos - (IW+1)'(NUM_REQ);
            end
            if (!o_valid && i_req[pos[IW-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory-port ownership arbiter (IDLE/BUSY/DRAIN) with registered one-hot grant.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_MEM_REQ
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic [NUM_REQ-1:0]         i_req,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic                       o_mem_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_mem_sel,
    input  logic                       i_mem_done,
    output logic                       o_mem_kill
);

    localparam int IW = $clog2(NUM_REQ);

    mem_arb_state_t     state, state_n;
    logic [NUM_REQ-1:0] grant, grant_n;
    logic [IW-1:0]      sel, sel_n;
    logic               kill, kill_n;
    logic [IW-1:0]      ptr;
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic               take;

    assign take = (state == IDLE) && !i_flush && pick_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_n;

    always_comb begin
        ptr_n = ptr;
        if (take) begin
            ptr_n = (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + IW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_n;
        end
    end
`else
    assign ptr = '0;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .i_req   (i_req),
        .i_ptr   (ptr),
        .o_valid (pick_valid),
        .o_idx   (pick_idx)
    );

    always_comb begin
        state_n = state;
        grant_n = grant;
        sel_n   = sel;
        kill_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (take) begin
                    state_n           = BUSY;
                    grant_n           = '0;
                    grant_n[pick_idx] = 1'b1;
                    sel_n             = pick_idx;
                end
            end
            BUSY: begin
                // done wins over a coincident flush: the access completed
                if (i_mem_done) begin
                    state_n = IDLE;
                    grant_n = '0;
                end else if (i_flush) begin
                    state_n = DRAIN;
                    grant_n = '0;
                    kill_n  = 1'b1;
                end
            end
            DRAIN: begin
                if (i_mem_done) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            kill  <= 1'b0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            sel   <= sel_n;
            kill  <= kill_n;
        end
    end

    assign o_grant     = grant;
    assign o_mem_valid = (state == BUSY);
    assign o_mem_sel   = sel;
    assign o_mem_kill  = kill;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised self-checking bench for mem_arbiter (NUM_REQ=3).
module tb_mem_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_flush;
    logic [2:0] i_req;
    logic [2:0] o_grant;
    logic       o_mem_valid;
    logic [1:0] o_mem_sel;
    logic       i_mem_done;
    logic       o_mem_kill;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mem_arbiter #(
        .NUM_REQ (3)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_flush),
        .i_req       (i_req),
        .o_grant     (o_grant),
        .o_mem_valid (o_mem_valid),
        .o_mem_sel   (o_mem_sel),
        .i_mem_done  (i_mem_done),
        .o_mem_kill  (o_mem_kill)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // advance one rising edge and settle just after it
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_reset();
        i_rst_n = 1'b0;
        #2;
        i_rst_n = 1'b1;
    endtask

    logic [2:0] exp_order [4];
    logic       in_drain;
    logic       drv_done;

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_order = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        i_rst_n    = 1'b0;
        i_flush    = 1'b0;
        i_req      = '0;
        i_mem_done = 1'b0;
        tick();
        tick();
        check_eq("rst_grant", 8'(o_grant), 8'h0);
        check_eq("rst_valid", 8'(o_mem_valid), 8'h0);
        check_eq("rst_sel", 8'(o_mem_sel), 8'h0);
        check_eq("rst_kill", 8'(o_mem_kill), 8'h0);
        i_rst_n = 1'b1;

        // single request, one-cycle latency, grant held until done
        i_req = 3'b010;
        tick();
        check_eq("grant1", 8'(o_grant), 8'h2);
        check_eq("sel1", 8'(o_mem_sel), 8'h1);
        check_eq("valid1", 8'(o_mem_valid), 8'h1);
        i_req = 3'b101;
        tick();
        tick();
        check_eq("grant_hold", 8'(o_grant), 8'h2);
        i_mem_done = 1'b1;
        tick();
        i_mem_done = 1'b0;
        i_req = '0;
        check_eq("done_grant", 8'(o_grant), 8'h0);
        check_eq("done_valid", 8'(o_mem_valid), 8'h0);
        check_eq("done_sel_hold", 8'(o_mem_sel), 8'h1);
        check_eq("done_kill", 8'(o_mem_kill), 8'h0);

        // arbitration order with all requesters active
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            i_req = 3'b111;
            tick();
            check_eq($sformatf("order%0d", k), 8'(o_grant), 8'(exp_order[k]));
            tick();
            i_mem_done = 1'b1;
            tick();
            i_mem_done = 1'b0;
        end

        // flush in BUSY: kill pulse, DRAIN ignores requests and flush
        i_req = '0;
        pulse_reset();
        i_req = 3'b100;
        tick();
        check_eq("own2_grant", 8'(o_grant), 8'h4);
        check_eq("own2_sel", 8'(o_mem_sel), 8'h2);
        i_req = 3'b001;
        tick();
        i_flush = 1'b1;
        tick();
        check_eq("kill_pulse", 8'(o_mem_kill), 8'h1);
        check_eq("kill_grant", 8'(o_grant), 8'h0);
        check_eq("kill_valid", 8'(o_mem_valid), 8'h0);
        check_eq("kill_sel_hold", 8'(o_mem_sel), 8'h2);
        i_flush = 1'b0;
        tick();
        check_eq("kill_one_cycle", 8'(o_mem_kill), 8'h0);
        check_eq("drain_no_grant", 8'(o_grant), 8'h0);
        i_flush = 1'b1;
        tick();
        check_eq("drain_flush_kill", 8'(o_mem_kill), 8'h0);
        check_eq("drain_flush_grant", 8'(o_grant), 8'h0);
        i_flush = 1'b0;
        i_mem_done = 1'b1;
        tick();
        i_mem_done = 1'b0;
        check_eq("drain_exit_grant", 8'(o_grant), 8'h0);
        tick();
        check_eq("post_drain_grant", 8'(o_grant), 8'h1);
        check_eq("post_drain_sel", 8'(o_mem_sel), 8'h0);

        // flush and done together count as done
        i_flush = 1'b1;
        i_mem_done = 1'b1;
        tick();
        check_eq("fd_kill", 8'(o_mem_kill), 8'h0);
        check_eq("fd_grant", 8'(o_grant), 8'h0);
        i_flush = 1'b0;
        i_mem_done = 1'b0;
        i_req = 3'b010;
        tick();
        check_eq("fd_idle_regrant", 8'(o_grant), 8'h2);

        // flush in IDLE suppresses arbitration for that cycle
        i_mem_done = 1'b1;
        tick();
        i_mem_done = 1'b0;
        i_req = 3'b100;
        i_flush = 1'b1;
        tick();
        check_eq("idle_flush_grant", 8'(o_grant), 8'h0);
        i_flush = 1'b0;
        tick();
        check_eq("idle_after_flush", 8'(o_grant), 8'h4);

        // done while IDLE is ignored
        i_mem_done = 1'b1;
        tick();
        i_req = '0;
        tick();
        check_eq("idle_done_grant", 8'(o_grant), 8'h0);
        check_eq("idle_done_kill", 8'(o_mem_kill), 8'h0);
        i_mem_done = 1'b0;
        i_req = 3'b010;
        tick();
        check_eq("idle_done_regrant", 8'(o_grant), 8'h2);

        // asynchronous reset mid-BUSY, stray done afterwards
        i_req = '0;
        #2;
        i_rst_n = 1'b0;
        i_mem_done = 1'b1;
        #1;
        check_eq("arst_grant", 8'(o_grant), 8'h0);
        check_eq("arst_valid", 8'(o_mem_valid), 8'h0);
        check_eq("arst_sel", 8'(o_mem_sel), 8'h0);
        check_eq("arst_kill", 8'(o_mem_kill), 8'h0);
        #1;
        i_rst_n = 1'b1;
        tick();
        check_eq("stray_done_grant", 8'(o_grant), 8'h0);
        check_eq("stray_done_valid", 8'(o_mem_valid), 8'h0);
        check_eq("stray_done_kill", 8'(o_mem_kill), 8'h0);
        i_mem_done = 1'b0;
        i_req = 3'b111;
        tick();
        check_eq("ptr_reset_grant", 8'(o_grant), 8'h1);

        // randomised traffic: grant stays one-hot, no grant while draining
        i_req = '0;
        pulse_reset();
        in_drain = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            i_req      = 3'($urandom_range(0, 7));
            i_flush    = ($urandom_range(0, 7) == 0);
            drv_done   = ($urandom_range(0, 3) == 0);
            i_mem_done = drv_done;
            tick();
            check_eq("rand_onehot", 8'($onehot0(o_grant)), 8'h1);
            check_eq("rand_valid", 8'(o_mem_valid), 8'(o_grant != 3'b000));
            if (in_drain) begin
                check_eq("rand_drain_grant", 8'(o_grant), 8'h0);
            end
            if (o_mem_kill) begin
                in_drain = 1'b1;
            end else if (in_drain && drv_done) begin
                in_drain = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of memory requesters (exec ports, page walker); legal range 2..8.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_flush  input  1  pipeline flush; cancels ownership.
REQ-005 SHALL have port i_req  input  NUM_REQ  per-requester memory-ready (each requester's o_mem_ready).
REQ-006 SHALL have port o_grant  output  NUM_REQ  one-hot ownership, drives each requester's i_mem_grant.
REQ-007 SHALL have port o_mem_valid  output  1  memory port owned and access live.
REQ-008 SHALL have port o_mem_sel  output  $clog2(NUM_REQ)  index of owning requester, mux select for address/data.
REQ-009 SHALL have port i_mem_done  input  1  one-cycle pulse, current access complete.
REQ-010 SHALL have port o_mem_kill  output  1  one-cycle pulse, in-flight access cancelled; response to be discarded.

Function
REQ-011 SHALL implement states IDLE, BUSY, DRAIN.
REQ-012 IDLE: any i_req bit set and i_flush low SHALL select a winner; next cycle state=BUSY, o_grant=winner one-hot, o_mem_valid=1, o_mem_sel=winner index.
REQ-013 Request-to-grant latency SHALL be exactly one cycle; grant is registered, never combinational from i_req.
REQ-014 BUSY: o_grant SHALL stay constant until i_mem_done, regardless of i_req changes.
REQ-015 BUSY with i_mem_done SHALL return to IDLE; o_grant, o_mem_valid clear next cycle; earliest new grant two cycles after done.
REQ-016 BUSY with i_flush and no i_mem_done SHALL pulse o_mem_kill next cycle, clear o_grant/o_mem_valid, enter DRAIN.
REQ-017 i_flush and i_mem_done same cycle in BUSY SHALL be treated as done: IDLE, no o_mem_kill.
REQ-018 DRAIN SHALL issue no grant; i_mem_done returns to IDLE; i_flush in DRAIN has no further effect.
REQ-019 i_flush in IDLE SHALL suppress arbitration that cycle.
REQ-020 i_mem_done outside BUSY/DRAIN SHALL be ignored.
REQ-021 o_grant SHALL never have more than one bit set; o_mem_sel SHALL hold last owner when o_mem_valid=0.
REQ-022 Arbitration pointer SHALL advance to winner+1 (mod NUM_REQ, wrap from NUM_REQ-1 to 0) on each grant.

Reset
REQ-023 Reset SHALL force state=IDLE, o_grant=0, o_mem_valid=0, o_mem_sel=0, o_mem_kill=0, pointer=0, asynchronously, mid-access included; a pending i_mem_done after reset SHALL be ignored.

Configuration
REQ-024 With MEM_ARB_ROUND_ROBIN_EN defined, winner SHALL be first set i_req bit at or after the pointer, wrapping.
REQ-025 Without MEM_ARB_ROUND_ROBIN_EN, winner SHALL be lowest set index (fixed priority); pointer logic absent.

Structure
REQ-026 State enum mem_arb_state_t and default NUM_MEM_REQ SHALL live in the shared config/include package.
REQ-027 Winner selection SHALL be sub-module rr_picker (i_req, i_ptr -> o_valid, o_idx); fixed-priority mode bypasses i_ptr.

Verification
REQ-028 i_req=3'b010 at cycle 0 -> o_grant=3'b010, o_mem_sel=1 at cycle 1; i_mem_done cycle 4 -> o_grant=0 cycle 5.
REQ-029 RR mode, i_req=3'b111 held, done every 3 cycles -> grant order 0,1,2,0; fixed mode -> 0,0,0.
REQ-030 BUSY owner 2, i_flush cycle 3 -> o_mem_kill=1 cycle 4, DRAIN; i_req=3'b001 ignored until i_mem_done cycle 6; grant 3'b001 cycle 8.
REQ-031 BUSY, i_flush and i_mem_done same cycle -> IDLE next cycle, o_mem_kill stays 0.
REQ-032 i_rst_n low mid-BUSY -> outputs zero immediately (no clock edge), pointer=0; stray i_mem_done after release ignored.
REQ-033 Random i_req/i_flush/i_mem_done 10k cycles -> $onehot0(o_grant) always, no grant while DRAIN.
